// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the serial add/sub engine.
// The master side issues start with operands; the slave side is the engine.
interface serial_add_sub_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle add/subtract engine: a WIDTH-bit operand pair is consumed
// DIGIT bits per clock through a small ripple slice, with the carry held in a
// register between digits. Subtract is a + ~b + ~borrow_in.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; results hold
// RUN   | one digit per clock, LSB digit first
// DONE  | one-cycle done pulse; a new start is accepted here too
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_sub_if.slave bus
);
    localparam int N  = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_add_sub: WIDTH must be >= 1 and a multiple of DIGIT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic [WIDTH-1:0] dig_ext;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_eff;
    logic             accept;

    assign b_eff  = bus.sub ? ~bus.b : bus.b;
    assign accept = bus.start && (state_q != S_RUN);

    // Ripple slice: add the low digit of both operand shifters plus the carry.
    always_comb begin
        logic c;
        c       = carry_q;
        dig_sum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dig_sum[i] = a_sh_q[i] ^ b_sh_q[i] ^ c;
            c          = (a_sh_q[i] & b_sh_q[i]) | (c & (a_sh_q[i] ^ b_sh_q[i]));
        end
        dig_cout = c;
    end

    // New digit enters the result shifter from the top; after N digits the
    // first digit has reached bit 0. Shift form keeps DIGIT == WIDTH legal.
    always_comb begin
        dig_ext                = '0;
        dig_ext[DIGIT-1:0]     = dig_sum;
        res_next               = (res_sh_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = b_eff;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    // Operand shifters lose their MSBs, so keep them for ovf.
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                res_sh_d = res_next;
                carry_d  = dig_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_DIGIT) begin
                    sum_d   = res_next;
                    cout_d  = dig_cout;
                    ovf_d   = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, including results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: a cycle-level reference model for the 16/4
// instance compared every cycle, directed literal cases, plus the 4/1 and
// 16/16 configurations.
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_sub_if #(.WIDTH(16)) bus16 ();
    serial_add_sub_if #(.WIDTH(4))  bus4 ();
    serial_add_sub_if #(.WIDTH(16)) busw ();

    serial_add_sub #(.WIDTH(16), .DIGIT(4))  dut    (.clk(clk), .rst(rst), .bus(bus16));
    serial_add_sub #(.WIDTH(4),  .DIGIT(1))  dut_w4 (.clk(clk), .rst(rst), .bus(bus4));
    serial_add_sub #(.WIDTH(16), .DIGIT(16)) dut_d16(.clk(clk), .rst(rst), .bus(busw));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: returns {ovf, cout, sum} from integer math.
    function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
        logic [16:0] u;
        logic [15:0] s16;
        logic        co;
        int          s;
        if (!sub) begin
            u   = {1'b0, a} + {1'b0, b} + 17'(cin);
            s16 = u[15:0];
            co  = u[16];
            s   = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end else begin
            s16 = a - b - 16'(cin);
            co  = (int'(a) >= int'(b) + int'(cin));
            s   = int'($signed(a)) - int'($signed(b)) - int'(cin);
        end
        return {((s > 32767) || (s < -32768)), co, s16};
    endfunction

    // Model: an accepted op occupies 4 busy cycles, then one done cycle.
    int          m_left;
    logic [17:0] p_res;
    logic [15:0] m_sum;
    logic        m_cout, m_ovf, m_busy, m_done;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_busy <= (m_left > 1);
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_sum  <= p_res[15:0];
                m_cout <= p_res[16];
                m_ovf  <= p_res[17];
            end
        end else begin
            m_done <= 1'b0;
            if (bus16.start) begin
                p_res  <= ref_op(bus16.a, bus16.b, bus16.cin, bus16.sub);
                m_left <= 4;
                m_busy <= 1'b1;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_busy", 32'(bus16.busy), 32'(m_busy));
        check("model_done", 32'(bus16.done), 32'(m_done));
        check("model_sum",  32'(bus16.sum),  32'(m_sum));
        check("model_cout", 32'(bus16.cout), 32'(m_cout));
        check("model_ovf",  32'(bus16.ovf),  32'(m_ovf));
    end

    // Done spacing while start is held high.
    logic hold_phase = 1'b0;
    int   prev_done  = -1;
    always @(negedge clk) begin
        if (hold_phase && bus16.done) begin
            if (prev_done >= 0) check("hold_done_spacing", 32'(cyc - prev_done), 32'd5);
            prev_done <= cyc;
        end
    end

    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s,
                          input logic [15:0] es, input logic ec, input logic eo);
        int nb = 0;
        int guard = 0;
        @(negedge clk);
        bus16.a = a; bus16.b = b; bus16.cin = c; bus16.sub = s; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        while (!bus16.done && guard < 20) begin
            if (bus16.busy) nb++;
            @(negedge clk);
            guard++;
        end
        check({nm, "_timeout"}, 32'(guard < 20), 32'd1);
        check({nm, "_busy_cycles"}, 32'(nb), 32'd4);
        check({nm, "_sum"},  32'(bus16.sum),  32'(es));
        check({nm, "_cout"}, 32'(bus16.cout), 32'(ec));
        check({nm, "_ovf"},  32'(bus16.ovf),  32'(eo));
        @(negedge clk);
        check({nm, "_done_one_cycle"}, 32'(bus16.done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        int seen;
        bus16.start = 0; bus16.sub = 0; bus16.a = 0; bus16.b = 0; bus16.cin = 0;
        bus4.start  = 0; bus4.sub  = 0; bus4.a  = 0; bus4.b  = 0; bus4.cin  = 0;
        busw.start  = 0; busw.sub  = 0; busw.a  = 0; busw.b  = 0; busw.cin  = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus16.busy), 32'd0);
        check("rst_done", 32'(bus16.done), 32'd0);
        check("rst_sum",  32'(bus16.sum),  32'd0);
        check("rst_cout", 32'(bus16.cout), 32'd0);
        check("rst_ovf",  32'(bus16.ovf),  32'd0);
        rst = 1'b0;

        check("pin_add",  32'(ref_op(16'h1234, 16'h4321, 1'b0, 1'b0)), 32'({1'b0, 1'b0, 16'h5555}));
        check("pin_wrap", 32'(ref_op(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'({1'b0, 1'b1, 16'h0000}));
        check("pin_sub",  32'(ref_op(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'({1'b1, 1'b1, 16'h7FFF}));

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_bin",   16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

        // Reset on the second RUN edge aborts the op.
        @(negedge clk);
        bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.cin = 0; bus16.sub = 0; bus16.start = 1;
        @(negedge clk);
        bus16.start = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus16.busy), 32'd0);
        check("abort_done", 32'(bus16.done), 32'd0);
        check("abort_sum",  32'(bus16.sum),  32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus16.done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // start held high with operands changing every cycle.
        hold_phase = 1'b1;
        bus16.start = 1'b1;
        repeat (32) begin
            bus16.a   = 16'($urandom);
            bus16.b   = 16'($urandom);
            bus16.cin = 1'($urandom_range(0, 1));
            bus16.sub = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus16.start = 1'b0;
        hold_phase  = 1'b0;
        repeat (7) @(negedge clk);

        // Random traffic with sparse starts.
        repeat (400) begin
            bus16.start = ($urandom_range(0, 2) == 0);
            bus16.a     = 16'($urandom);
            bus16.b     = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            bus16.cin   = 1'($urandom_range(0, 1));
            bus16.sub   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus16.start = 1'b0;
        repeat (7) @(negedge clk);

        // WIDTH=4, DIGIT=1: exhaustive add against plain 4-bit addition.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    logic [4:0] exp5;
                    exp5 = 5'(ia) + 5'(ib) + 5'(ic);
                    bus4.a = 4'(ia); bus4.b = 4'(ib); bus4.cin = 1'(ic); bus4.sub = 1'b0;
                    bus4.start = 1'b1;
                    @(negedge clk);
                    bus4.start = 1'b0;
                    guard = 0;
                    while (!bus4.done && guard < 10) begin
                        @(negedge clk);
                        guard++;
                    end
                    check("w4_add", 32'({bus4.cout, bus4.sum}), 32'(exp5));
                end
            end
        end
        @(negedge clk);

        // WIDTH=16, DIGIT=16: single RUN cycle.
        busw.a = 16'hABCD; busw.b = 16'h1111; busw.cin = 0; busw.sub = 0; busw.start = 1'b1;
        @(negedge clk);
        busw.start = 1'b0;
        check("d16_busy", 32'(busw.busy), 32'd1);
        check("d16_done_early", 32'(busw.done), 32'd0);
        @(negedge clk);
        check("d16_done", 32'(busw.done), 32'd1);
        check("d16_sum",  32'(busw.sum),  32'h0000BCDE);
        check("d16_cout", 32'(busw.cout), 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the 4-bit ripple-carry full-adder chain.
- Processes a WIDTH-bit operand pair DIGIT bits per clock, using a registered carry between digits. Replaces a wide combinational ripple with a small ripple slice plus an FSM.
- Uses a start/busy/done handshake. Adds subtract mode and signed overflow detection.
- Sits in the arithmetic-logic library as the shared wide add/sub engine for datapaths that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be >= 1.
- DIGIT, 4, bits processed per clock. Must be >= 1, and WIDTH mod DIGIT must be 0. Elaboration fails otherwise.
- (derived) N = WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk    input   1      clock; all state updates on the rising edge
- rst    input   1      synchronous, active-high reset
- start  input   1      request a new operation; sampled only when accepted (see Behaviour)
- sub    input   1      0: add, 1: subtract; sampled at accept
- a      input   WIDTH  operand A; sampled at accept
- b      input   WIDTH  operand B; sampled at accept
- cin    input   1      carry-in (add) or borrow-in (subtract); sampled at accept
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse; result valid
- sum    output  WIDTH  result, registered
- cout   output  1      carry-out (add); inverted borrow (subtract: 1 = no borrow)
- ovf    output  1      two's-complement signed overflow

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset (rst=1 at a rising edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal registers cleared.
  - rst has priority over every other input.
  - Reset mid-RUN aborts the operation: no done pulse, result not updated (cleared by reset).
- FSM states: IDLE, RUN, DONE.
- Accept condition: start=1 while state is IDLE or DONE. start in RUN is ignored, not queued.
- On accept:
  - Latch a into an operand shift register.
  - Latch b_eff = sub ? ~b : b.
  - Set carry register = cin ^ sub. Subtract therefore computes a - b - cin = a + ~b + ~cin.
  - Clear digit counter; state -> RUN.
- RUN, each edge, for digit k (k = 0..N-1, LSB digit first):
  - DIGIT-bit ripple add of the operand digits plus the carry register.
  - Store the digit into the result shift register; update the carry register; increment k.
  - a, b, sub and cin changes during RUN have no effect.
- Completion: at the edge processing k=N-1, transfer the result shift register to sum, set cout = final carry and ovf, and go to DONE.
- Latency: if start is accepted at edge t0, busy=1 from after t0 until edge tN; done=1 for exactly the one cycle after tN.
- DONE lasts one cycle, then IDLE unless start=1, which is accepted (back-to-back: one op per N+1 cycles).
- sum, cout and ovf hold their value from completion until the next completion or reset. They are not cleared at accept.
- ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), using the latched operands.
- Arithmetic is modulo 2^WIDTH; wrap-around is reported only via cout and ovf.
- DIGIT == WIDTH is legal: N=1, a single RUN cycle.
- WIDTH=4, DIGIT=1 must match the 4-bit ripple adder for all 512 input combinations when sub=0.
- The counter is sized ceil(log2(N+1)) bits; there is no overflow of the counter.

Test Plan (WIDTH=16, DIGIT=4 unless stated):
- Basic add: a=0x1234, b=0x4321, cin=0, sub=0, start pulsed at t0.
  - busy high for 4 cycles; done=1 in the cycle after t4.
  - sum=0x5555, cout=0, ovf=0.
- Carry/overflow boundaries:
  - 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x0010-0x0003, cin=1 -> sum=0x000C, cout=1.
- Reset mid-operation: start, then rst=1 on the 2nd RUN edge.
  - Next cycle: busy=0, done=0, sum=0; no done pulse follows.
  - A subsequent start of 0x0001+0x0001 gives sum=0x0002.
- Handshake robustness: hold start=1 continuously and change a/b every cycle.
  - Starts during RUN are ignored; each result matches the operands latched at accept.
  - A new op is accepted in each DONE cycle, so done pulses every 5 cycles.
  - sum holds between pulses.
- Parameter sweep:
  - WIDTH=4, DIGIT=1: exhaustive 16x16x2 add compares against the 4-bit ripple adder model (sum, cout).
  - WIDTH=16, DIGIT=16: 0xABCD+0x1111 -> 0xBCDE with done 1 cycle after accept.
